// File: rtl/jtframe_pkg.sv
// Shared definitions for the pause controller: FSM state encoding, dim levels,
// counter widths and the dim level lookup used when dimming is compiled in.
package jtframe_pkg;

    localparam int unsigned DEB_CW = 16;
    localparam int unsigned FCNT_W = 12;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_PAUSED   = 2'd1,
        ST_REL_WAIT = 2'd2
    } pause_st_e;

    localparam logic [1:0] DIM_NONE = 2'd0;
    localparam logic [1:0] DIM_LOW  = 2'd1;
    localparam logic [1:0] DIM_MID  = 2'd2;
    localparam logic [1:0] DIM_MAX  = 2'd3;

    // Dim level for a given paused frame count: first level at fr, then one
    // more level every step frames, saturating at DIM_MAX.
    function automatic logic [1:0] dim_level(
        input logic [FCNT_W-1:0] fcnt,
        input logic [FCNT_W-1:0] fr,
        input logic [7:0]        step
    );
        logic [FCNT_W+1:0] f;
        logic [FCNT_W+1:0] t1;
        logic [FCNT_W+1:0] t2;
        logic [FCNT_W+1:0] t3;
        f  = (FCNT_W+2)'(fcnt);
        t1 = (FCNT_W+2)'(fr);
        t2 = t1 + (FCNT_W+2)'(step);
        t3 = t2 + (FCNT_W+2)'(step);
        if (f >= t3)      return DIM_MAX;
        else if (f >= t2) return DIM_MID;
        else if (f >= t1) return DIM_LOW;
        else              return DIM_NONE;
    endfunction

endpackage

// File: rtl/jtframe_debounce.sv
// Generic level debouncer: each bit of dout_o follows din_i only after the
// input has differed from the accepted level for COUNT consecutive samples.
// Ports: clk, rst (sync, active high), din_i[WIDTH] raw levels,
//        dout_o[WIDTH] debounced levels (registered).
module jtframe_debounce
    import jtframe_pkg::*;
#(
    parameter int unsigned       WIDTH = 1,
    parameter logic [DEB_CW-1:0] COUNT = 16'd4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0]  dout_q;
    logic [WIDTH-1:0]  dout_d;
    logic [DEB_CW-1:0] cnt_q [WIDTH];
    logic [DEB_CW-1:0] cnt_d [WIDTH];

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        dout_d = dout_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (din_i[i] != dout_q[i]) begin
                if (cnt_q[i] >= COUNT - DEB_CW'(1)) begin
                    dout_d[i] = din_i[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/jtframe_pause_ctl.sv
// Frame-aligned pause controller. Merges keyboard/gamepad pause toggles,
// resume buttons and the OSD pause level into game_pause, changed only on a
// vs rising edge.
// Ports: clk, rst (sync, active high), vs, key_pause, joy_pause, resume,
//        osd_pause in; game_pause (registered), pause_evt (1-cycle strobe the
//        cycle after game_pause changes), dim[1:0] out.
// Optional: JTFRAME_PAUSE_DIM_EN enables progressive video dimming after
//           DIM_FR paused frames; otherwise dim is constant 0.
module jtframe_pause_ctl
    import jtframe_pkg::*;
#(
    parameter logic [15:0] DEB_CNT  = 16'd4095
`ifdef JTFRAME_PAUSE_DIM_EN
    ,
    parameter logic [11:0] DIM_FR   = 12'd1800,
    parameter logic [7:0]  DIM_STEP = 8'd64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs,
    input  logic       key_pause,
    input  logic       joy_pause,
    input  logic       resume,
    input  logic       osd_pause,
    output logic       game_pause,
    output logic       pause_evt,
    output logic [1:0] dim
);

    pause_st_e state_q, state_d;
    logic      tg_lvl, res_lvl;
    logic      tg_l_q, res_l_q, vs_l_q;
    logic      pend_on_q, pend_on_d;
    logic      pend_off_q, pend_off_d;
    logic      pend_res_q, pend_res_d;
    logic      game_pause_q, game_pause_d;
    logic      gp_l_q;
    logic      pause_evt_q, pause_evt_d;
    logic      tg_rise, res_rise, vs_rise;

    jtframe_debounce #(.WIDTH(1), .COUNT(DEB_CNT)) u_deb_tg (
        .clk    (clk),
        .rst    (rst),
        .din_i  (key_pause | joy_pause),
        .dout_o (tg_lvl)
    );

    jtframe_debounce #(.WIDTH(1), .COUNT(DEB_CNT)) u_deb_res (
        .clk    (clk),
        .rst    (rst),
        .din_i  (resume),
        .dout_o (res_lvl)
    );

    assign tg_rise  = tg_lvl  & ~tg_l_q;
    assign res_rise = res_lvl & ~res_l_q;
    assign vs_rise  = vs      & ~vs_l_q;

    // Edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            tg_l_q  <= 1'b0;
            res_l_q <= 1'b0;
            vs_l_q  <= 1'b0;
        end else begin
            tg_l_q  <= tg_lvl;
            res_l_q <= res_lvl;
            vs_l_q  <= vs;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pend_on_q    <= 1'b0;
            pend_off_q   <= 1'b0;
            pend_res_q   <= 1'b0;
            game_pause_q <= 1'b0;
            gp_l_q       <= 1'b0;
            pause_evt_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_on_q    <= pend_on_d;
            pend_off_q   <= pend_off_d;
            pend_res_q   <= pend_res_d;
            game_pause_q <= game_pause_d;
            gp_l_q       <= game_pause_q;
            pause_evt_q  <= pause_evt_d;
        end
    end

    // Requests are latched any time; they only take effect on a vs rise.
    always_comb begin
        state_d      = state_q;
        pend_on_d    = pend_on_q;
        pend_off_d   = pend_off_q;
        pend_res_d   = pend_res_q;
        game_pause_d = game_pause_q;
        pause_evt_d  = game_pause_q ^ gp_l_q;

        unique case (state_q)
            ST_RUN: begin
                // A second press before the frame edge withdraws the request.
                if (tg_rise) pend_on_d = ~pend_on_q;
                if (vs_rise && pend_on_q) begin
                    state_d   = ST_PAUSED;
                    pend_on_d = 1'b0;
                end
            end
            ST_PAUSED: begin
                // Resume takes priority so the release wait is always armed.
                if (res_rise) begin
                    pend_off_d = 1'b1;
                    pend_res_d = 1'b1;
                end else if (tg_rise) begin
                    pend_off_d = 1'b1;
                end
                if (vs_rise && pend_off_q) begin
                    state_d    = pend_res_q ? ST_REL_WAIT : ST_RUN;
                    pend_off_d = 1'b0;
                    pend_res_d = 1'b0;
                end
            end
            ST_REL_WAIT: begin
                // Keep the held start/coin button from re-pausing the game.
                if (!tg_lvl && !res_lvl) state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_RUN;
                pend_on_d  = 1'b0;
                pend_off_d = 1'b0;
                pend_res_d = 1'b0;
            end
        endcase

        if (vs_rise) game_pause_d = (state_d == ST_PAUSED) | osd_pause;
    end

    assign game_pause = game_pause_q;
    assign pause_evt  = pause_evt_q;

`ifdef JTFRAME_PAUSE_DIM_EN
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [1:0]        dim_q, dim_d;

    // Count paused frames (saturating); clear on the first running frame.
    always_comb begin
        fcnt_d = fcnt_q;
        dim_d  = dim_q;
        if (vs_rise) begin
            if (game_pause_q) begin
                if (fcnt_q != '1) fcnt_d = fcnt_q + FCNT_W'(1);
                dim_d = dim_level(fcnt_d, DIM_FR, DIM_STEP);
            end else begin
                fcnt_d = '0;
                dim_d  = DIM_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
            dim_q  <= DIM_NONE;
        end else begin
            fcnt_q <= fcnt_d;
            dim_q  <= dim_d;
        end
    end

    assign dim = dim_q;
`else
    assign dim = DIM_NONE;
`endif

endmodule

// File: tb/tb_jtframe_pause_ctl.sv
// Bench for jtframe_pause_ctl: table of per-step input levels with expected
// outputs after a number of 100-cycle frames, plus hand sequences for
// latency, pause_evt, cancel, no-vs and reset corner cases.
module tb_jtframe_pause_ctl;

    localparam int unsigned FRAME = 100;
    localparam int unsigned VS_HI = 4;

    logic       clk;
    logic       rst;
    logic       vs;
    logic       key_pause;
    logic       joy_pause;
    logic       resume;
    logic       osd_pause;
    logic       game_pause;
    logic       pause_evt;
    logic [1:0] dim;

    int n_cmp;
    int n_bad;
    int evt_seen;

    typedef struct {
        logic       key;
        logic       joy;
        logic       res;
        logic       osd;
        int         nfr;
        logic       gp;
        logic [1:0] dimx;
    } vec_t;

    vec_t vq[$];

    jtframe_pause_ctl #(
        .DEB_CNT  (16'd16)
`ifdef JTFRAME_PAUSE_DIM_EN
        ,
        .DIM_FR   (12'd4),
        .DIM_STEP (8'd2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vs         (vs),
        .key_pause  (key_pause),
        .joy_pause  (joy_pause),
        .resume     (resume),
        .osd_pause  (osd_pause),
        .game_pause (game_pause),
        .pause_evt  (pause_evt),
        .dim        (dim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pause_evt) evt_seen++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic run_frame();
        vs = 1'b1;
        idle(VS_HI);
        vs = 1'b0;
        idle(FRAME - VS_HI);
    endtask

    task automatic press_key(input int hi, input int lo);
        key_pause = 1'b1;
        idle(hi);
        key_pause = 1'b0;
        idle(lo);
    endtask

    function automatic int exp_dim(input logic [1:0] d);
`ifdef JTFRAME_PAUSE_DIM_EN
        return int'(d);
`else
        return int'(d) & 0;
`endif
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        evt_seen = 0;
        rst = 1'b1;
        vs = 1'b0;
        key_pause = 1'b0;
        joy_pause = 1'b0;
        resume = 1'b0;
        osd_pause = 1'b0;

        //         key   joy   res   osd  nfr gp   dim
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 2'd1});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 2'd1});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 2'd2});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 2'd3});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 2'd3});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 2'd3});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 2'd1});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 2'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 2'd0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 2'd0});

        idle(3);
        check("reset game_pause", int'(game_pause), 0);
        check("reset pause_evt", int'(pause_evt), 0);
        check("reset dim", int'(dim), 0);
        rst = 1'b0;
        idle(2);

        // Table: apply levels, run frames, compare steady-state outputs.
        for (int i = 0; i < vq.size(); i++) begin
            key_pause = vq[i].key;
            joy_pause = vq[i].joy;
            resume    = vq[i].res;
            osd_pause = vq[i].osd;
            for (int f = 0; f < vq[i].nfr; f++) run_frame();
            check($sformatf("vec%0d game_pause", i), int'(game_pause), int'(vq[i].gp));
            check($sformatf("vec%0d dim", i), int'(dim), exp_dim(vq[i].dimx));
        end
        key_pause = 1'b0;
        joy_pause = 1'b0;
        resume    = 1'b0;
        osd_pause = 1'b0;

        // Press shorter than the debounce window is ignored while paused.
        press_key(8, 30);
        run_frame();
        run_frame();
        check("short press keeps pause", int'(game_pause), 1);

        // Accepted toggle unpauses at the next frame edge.
        press_key(30, 30);
        run_frame();
        check("toggle unpause", int'(game_pause), 0);

        // Two presses inside one frame cancel each other.
        press_key(30, 30);
        press_key(30, 30);
        run_frame();
        run_frame();
        check("double tap cancels", int'(game_pause), 0);

        // Pending request waits indefinitely without vs.
        press_key(30, 30);
        idle(500);
        check("no vs keeps running", int'(game_pause), 0);

        // Pause lands on the vs edge; pause_evt follows one cycle later.
        vs = 1'b1;
        tick();
        check("vs edge game_pause", int'(game_pause), 1);
        check("evt on change cycle", int'(pause_evt), 0);
        tick();
        check("evt pulse", int'(pause_evt), 1);
        tick();
        check("evt one cycle", int'(pause_evt), 0);
        vs = 1'b0;
        idle(FRAME);

        // Reset mid-frame with a resume request pending clears everything.
        resume = 1'b1;
        idle(30);
        rst = 1'b1;
        tick();
        check("rst game_pause", int'(game_pause), 0);
        check("rst pause_evt", int'(pause_evt), 0);
        check("rst dim", int'(dim), 0);
        rst = 1'b0;
        resume = 1'b0;
        evt_seen = 0;
        run_frame();
        run_frame();
        check("post-rst game_pause", int'(game_pause), 0);
        check("post-rst no evt", evt_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
